// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serialiser state encodings.
package mmio_uart_tx_pkg;

    localparam logic [3:0] REG_TXDATA  = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_DIVISOR = 4'h8;

    localparam int STATUS_FULL   = 0;
    localparam int STATUS_EMPTY  = 1;
    localparam int STATUS_BUSY   = 2;
    localparam int STATUS_PARITY = 3;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } txState_t;

    // funct3 codes 011, 110 and 111 have no load/store meaning on this bus
    function automatic logic isReservedFunct3(input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; a push into a full FIFO is
// accepted when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_resetN,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_popData,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_doPop   = i_pop && !o_empty;
    assign w_doPush  = i_push && (!o_full || w_doPop);
    assign o_popData = r_mem[r_rdPtr];

    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus decode, stall handshake and bit serialiser.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0000_1000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd104
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [31:0] req_address,
    input  logic [2:0]  req_subfunction,
    input  logic [31:0] req_write_data,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        decoding_error,
    output logic        tx_line,
    output logic        tx_busy
);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
`else
    localparam logic PARITY_PRESENT = 1'b0;
`endif

    txState_t    r_state;
    txState_t    w_nextState;
    logic [15:0] r_bitCount;
    logic [2:0]  r_bitIndex;
    logic [7:0]  r_txByte;
    logic [15:0] r_divisor;
    logic        r_loadDone;
    logic [31:0] r_readData;

    logic [3:0]  w_offset;
    logic        w_mapped;
    logic        w_legal;
    logic        w_regLoad;
    logic        w_txStore;
    logic        w_divStore;
    logic        w_push;
    logic        w_pop;
    logic        w_bitEnd;
    logic        w_fifoFull;
    logic        w_fifoEmpty;
    logic [7:0]  w_fifoData;
    logic [31:0] w_readValue;
    logic        w_unused;

    assign w_offset   = req_address[3:0];
    assign w_mapped   = req_valid && (req_address[31:4] == BASE_ADDRESS[31:4]);
    assign w_legal    = w_mapped && !isReservedFunct3(req_subfunction);
    assign w_regLoad  = w_legal && !req_is_store &&
                        ((w_offset == REG_TXDATA) || (w_offset == REG_STATUS) ||
                         (w_offset == REG_DIVISOR));
    assign w_txStore  = w_legal && req_is_store && (w_offset == REG_TXDATA);
    assign w_divStore = w_legal && req_is_store && (w_offset == REG_DIVISOR);
    assign w_push     = w_txStore && (!w_fifoFull || w_pop);
    assign w_unused   = &{1'b0, req_write_data[31:16]};

    assign stall          = (w_regLoad && !r_loadDone) || (w_txStore && !w_push);
    assign decoding_error = w_mapped && isReservedFunct3(req_subfunction);
    assign read_data      = r_loadDone ? r_readData : 32'd0;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .i_clk      (clk),
        .i_resetN   (reset_n),
        .i_push     (w_push),
        .i_pushData (req_write_data[7:0]),
        .i_pop      (w_pop),
        .o_popData  (w_fifoData),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty)
    );

    always_comb begin
        w_readValue = 32'd0;
        case (w_offset)
            REG_STATUS: begin
                w_readValue[STATUS_FULL]   = w_fifoFull;
                w_readValue[STATUS_EMPTY]  = w_fifoEmpty;
                w_readValue[STATUS_BUSY]   = tx_busy;
                w_readValue[STATUS_PARITY] = PARITY_PRESENT;
            end
            REG_DIVISOR: w_readValue = {16'd0, r_divisor};
            default:     w_readValue = 32'd0;
        endcase
    end

    // A register load stalls once and completes the next cycle from r_readData
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loadDone <= 1'b0;
            r_readData <= 32'd0;
            r_divisor  <= DEFAULT_DIVISOR;
        end else begin
            r_loadDone <= w_regLoad && !r_loadDone;
            if (w_regLoad && !r_loadDone) begin
                r_readData <= w_readValue;
            end
            if (w_divStore) begin
                r_divisor <= (req_write_data[15:0] == 16'd0) ? 16'd1 : req_write_data[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_bitEnd = (r_bitCount == 16'd0);

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_fifoEmpty) begin
                    w_nextState = TX_START;
                    w_pop       = 1'b1;
                end
            end
            TX_START: begin
                if (w_bitEnd) begin
                    w_nextState = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_bitEnd && (r_bitIndex == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_nextState = TX_PARITY;
`else
                    w_nextState = TX_STOP;
`endif
                end
            end
            TX_PARITY: begin
                if (w_bitEnd) begin
                    w_nextState = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_bitEnd) begin
                    if (!w_fifoEmpty) begin
                        w_nextState = TX_START;
                        w_pop       = 1'b1;
                    end else begin
                        w_nextState = TX_IDLE;
                    end
                end
            end
            default: w_nextState = TX_IDLE;
        endcase
    end

    // Reload at every bit boundary so a new divisor applies from the next bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitCount <= 16'd0;
            r_bitIndex <= 3'd0;
            r_txByte   <= 8'd0;
        end else begin
            if (w_pop) begin
                r_txByte <= w_fifoData;
            end
            if (w_pop || ((r_state != TX_IDLE) && w_bitEnd)) begin
                r_bitCount <= r_divisor - 16'd1;
            end else if (r_state != TX_IDLE) begin
                r_bitCount <= r_bitCount - 16'd1;
            end
            if ((r_state == TX_DATA) && w_bitEnd) begin
                r_bitIndex <= r_bitIndex + 3'd1;
            end
        end
    end

    always_comb begin
        tx_line = 1'b1;
        tx_busy = (r_state != TX_IDLE) || !w_fifoEmpty;
        case (r_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = r_txByte[r_bitIndex];
            TX_PARITY: tx_line = ^r_txByte;
            default:   tx_line = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx; honours UART_TX_PARITY_EN when the
// design is built with it.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS  = 11;
    localparam logic [31:0] STATUS_IDLE = 32'h0000_000A;
`else
    localparam int          FRAME_BITS  = 10;
    localparam logic [31:0] STATUS_IDLE = 32'h0000_0002;
`endif
    localparam logic [31:0] A_TXDATA  = 32'h0000_1000;
    localparam logic [31:0] A_STATUS  = 32'h0000_1004;
    localparam logic [31:0] A_DIVISOR = 32'h0000_1008;
    localparam logic [2:0]  F_BYTE    = 3'b000;
    localparam logic [2:0]  F_WORD    = 3'b010;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_is_store;
    logic [31:0] req_address;
    logic [2:0]  req_subfunction;
    logic [31:0] req_write_data;
    logic        stall;
    logic [31:0] read_data;
    logic        decoding_error;
    logic        tx_line;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_is_store    (req_is_store),
        .req_address     (req_address),
        .req_subfunction (req_subfunction),
        .req_write_data  (req_write_data),
        .stall           (stall),
        .read_data       (read_data),
        .decoding_error  (decoding_error),
        .tx_line         (tx_line),
        .tx_busy         (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Starts on a negedge, returns on the negedge after the request completes
    task automatic busAccess(input logic isStore, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] funct3,
                             output int stallCycles, output logic [31:0] rdata);
        req_valid       = 1'b1;
        req_is_store    = isStore;
        req_address     = addr;
        req_subfunction = funct3;
        req_write_data  = data;
        stallCycles     = 0;
        rdata           = 32'd0;
        for (int g = 0; g < 2000; g++) begin
            #1;
            if (!stall) begin
                rdata = read_data;
                break;
            end
            stallCycles++;
            @(negedge clk);
        end
        @(negedge clk);
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        if (stallCycles >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL bus_timeout: addr %h still stalled after %0d cycles, required completion", addr, stallCycles);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (tx_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_timeout: tx_busy %b, required 0", tx_busy);
        end
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        req_valid       = 1'b0;
        req_is_store    = 1'b0;
        req_address     = 32'd0;
        req_subfunction = 3'd0;
        req_write_data  = 32'd0;
        #3;
        checks += 5;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b, expected 0", stall); end
        if (read_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_read_data: got %h, expected 0", read_data); end
        if (decoding_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_decoding_error: got %b, expected 0", decoding_error); end
        if (tx_line !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_line: got %b, expected 1", tx_line); end
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_busy: got %b, expected 0", tx_busy); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_register_read();
        int          sc;
        logic [31:0] rd;
        busAccess(1'b0, A_STATUS, 32'd0, F_WORD, sc, rd);
        checks += 2;
        if (sc !== 1) begin errors++; $display("[TB] FAIL status_load_stall: got %0d cycles, expected 1", sc); end
        if (rd !== STATUS_IDLE) begin errors++; $display("[TB] FAIL status_after_reset: got %h, expected %h", rd, STATUS_IDLE); end
        busAccess(1'b0, A_DIVISOR, 32'd0, F_WORD, sc, rd);
        checks += 2;
        if (sc !== 1) begin errors++; $display("[TB] FAIL divisor_load_stall: got %0d cycles, expected 1", sc); end
        if (rd !== 32'd104) begin errors++; $display("[TB] FAIL divisor_default: got %0d, expected 104", rd); end
        busAccess(1'b0, 32'h0000_100C, 32'd0, F_WORD, sc, rd);
        checks += 2;
        if (sc !== 0) begin errors++; $display("[TB] FAIL other_offset_stall: got %0d cycles, expected 0", sc); end
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL other_offset_read: got %h, expected 0", rd); end
        busAccess(1'b0, 32'h0000_2004, 32'd0, F_WORD, sc, rd);
        checks++;
        if (sc !== 0) begin errors++; $display("[TB] FAIL unmapped_load_stall: got %0d cycles, expected 0", sc); end
    endtask

    // Checks every clock of a frame at divisor 4, then that tx_busy falls
    task automatic checkFrame(input logic [7:0] data, input string name);
        logic [FRAME_BITS-1:0] bits;
        int                    sc;
        logic [31:0]           rd;
        bits = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1 + k] = data[k];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^data;
`endif
        busAccess(1'b1, A_TXDATA, {24'hABCDEF, data}, F_BYTE, sc, rd);
        checks += 3;
        if (sc !== 0) begin errors++; $display("[TB] FAIL %s_push_stall: got %0d cycles, expected 0", name, sc); end
        if (tx_line !== 1'b1) begin errors++; $display("[TB] FAIL %s_pre_start: tx_line %b, expected 1", name, tx_line); end
        if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy_queued: tx_busy %b, expected 1", name, tx_busy); end
        for (int i = 0; i < FRAME_BITS * 4; i++) begin
            @(negedge clk);
            checks++;
            if (tx_line !== bits[i / 4]) begin
                errors++;
                $display("[TB] FAIL %s_cycle%0d: tx_line %b, expected %b", name, i, tx_line, bits[i / 4]);
            end
        end
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy_in_stop: got %b, expected 1", name, tx_busy); end
        @(negedge clk);
        checks += 2;
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_after_stop: got %b, expected 0", name, tx_busy); end
        if (tx_line !== 1'b1) begin errors++; $display("[TB] FAIL %s_idle_line: got %b, expected 1", name, tx_line); end
    endtask

    task automatic test_tx_frame();
        int          sc;
        logic [31:0] rd;
        busAccess(1'b1, A_DIVISOR, 32'd4, F_WORD, sc, rd);
        checks++;
        if (sc !== 0) begin errors++; $display("[TB] FAIL divisor_store_stall: got %0d cycles, expected 0", sc); end
        checkFrame(8'hA5, "frame_a5");
    endtask

    // The first byte leaves the FIFO as soon as the serialiser starts, so the
    // tenth store is the one that finds all eight slots occupied.
    task automatic test_back_to_back();
        int         stalls [10];
        logic [7:0] rxBytes [$];
        fork
            begin
                logic [31:0] rd;
                for (int i = 0; i < 10; i++) begin
                    busAccess(1'b1, A_TXDATA, 32'(8'hA0 + i), F_BYTE, stalls[i], rd);
                end
            end
            begin
                for (int n = 0; n < 10; n++) begin
                    logic       found;
                    logic [7:0] val;
                    found = 1'b0;
                    for (int g = 0; g < 3000; g++) begin
                        @(negedge clk);
                        if (tx_line == 1'b0) begin
                            found = 1'b1;
                            break;
                        end
                    end
                    if (!found) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL b2b_start_timeout: byte %0d never started, expected a start bit", n);
                        break;
                    end
                    val = 8'd0;
                    for (int k = 0; k < 8; k++) begin
                        repeat (4) @(negedge clk);
                        val[k] = tx_line;
                    end
                    repeat (4 * (FRAME_BITS - 9)) @(negedge clk);
                    rxBytes.push_back(val);
                end
            end
        join
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (stalls[i] !== 0) begin errors++; $display("[TB] FAIL b2b_stall%0d: got %0d cycles, expected 0", i, stalls[i]); end
        end
        checks++;
        if (stalls[9] !== FRAME_BITS * 4 - 8) begin
            errors++;
            $display("[TB] FAIL b2b_full_stall: got %0d cycles, expected %0d", stalls[9], FRAME_BITS * 4 - 8);
        end
        checks++;
        if (rxBytes.size() !== 10) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d bytes, expected 10", rxBytes.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rxBytes[i] !== 8'(8'hA0 + i)) begin
                    errors++;
                    $display("[TB] FAIL b2b_byte%0d: got %h, expected %h", i, rxBytes[i], 8'(8'hA0 + i));
                end
            end
        end
        waitIdle();
    endtask

    task automatic test_divisor();
        int          sc;
        logic [31:0] rd;
        int          runs [8];
        int          expRuns [8];
        busAccess(1'b1, A_DIVISOR, 32'd0, F_WORD, sc, rd);
        busAccess(1'b0, A_DIVISOR, 32'd0, F_WORD, sc, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("[TB] FAIL divisor_zero: got %0d, expected 1", rd); end
        busAccess(1'b1, A_DIVISOR, 32'd4, F_WORD, sc, rd);
        busAccess(1'b1, A_TXDATA, 32'h55, F_BYTE, sc, rd);
        // Write lands during data bit 0, so bit 1 onwards lasts 8 clocks
        expRuns = '{4, 4, 8, 8, 8, 8, 8, 8};
        fork
            begin
                int          sc2;
                logic [31:0] rd2;
                repeat (6) @(negedge clk);
                busAccess(1'b1, A_DIVISOR, 32'd8, F_WORD, sc2, rd2);
            end
            begin
                for (int g = 0; g < 100; g++) begin
                    @(negedge clk);
                    if (tx_line == 1'b0) break;
                end
                for (int r = 0; r < 8; r++) begin
                    logic level;
                    int   len;
                    level = tx_line;
                    len   = 0;
                    while (tx_line == level && len < 100) begin
                        len++;
                        @(negedge clk);
                    end
                    runs[r] = len;
                end
            end
        join
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (runs[r] !== expRuns[r]) begin
                errors++;
                $display("[TB] FAIL divisor_run%0d: lasted %0d clocks, expected %0d", r, runs[r], expRuns[r]);
            end
        end
        waitIdle();
        busAccess(1'b1, A_DIVISOR, 32'd4, F_WORD, sc, rd);
    endtask

    task automatic test_reserved_funct3();
        int          sc;
        logic [31:0] rd;
        req_valid       = 1'b1;
        req_is_store    = 1'b1;
        req_address     = A_TXDATA;
        req_subfunction = 3'b011;
        req_write_data  = 32'h33;
        #1;
        checks += 2;
        if (decoding_error !== 1'b1) begin errors++; $display("[TB] FAIL reserved_pulse: got %b, expected 1", decoding_error); end
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reserved_stall: got %b, expected 0", stall); end
        @(negedge clk);
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        #1;
        checks++;
        if (decoding_error !== 1'b0) begin errors++; $display("[TB] FAIL reserved_pulse_end: got %b, expected 0", decoding_error); end
        @(negedge clk);
        busAccess(1'b1, 32'h0000_2000, 32'h77, F_BYTE, sc, rd);
        checks++;
        if (sc !== 0) begin errors++; $display("[TB] FAIL unmapped_store_stall: got %0d cycles, expected 0", sc); end
        busAccess(1'b0, A_STATUS, 32'd0, F_WORD, sc, rd);
        checks += 2;
        if (rd !== STATUS_IDLE) begin errors++; $display("[TB] FAIL no_push_status: got %h, expected %h", rd, STATUS_IDLE); end
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL no_push_busy: got %b, expected 0", tx_busy); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        checkFrame(8'h07, "parity_07");
    endtask
`endif

    task automatic test_reset_mid_frame();
        int          sc;
        logic [31:0] rd;
        busAccess(1'b1, A_TXDATA, 32'h00, F_BYTE, sc, rd);
        busAccess(1'b1, A_TXDATA, 32'h00, F_BYTE, sc, rd);
        repeat (16) @(negedge clk);
        checks++;
        if (tx_line !== 1'b0) begin errors++; $display("[TB] FAIL midframe_bit3: got %b, expected 0", tx_line); end
        #2;
        reset_n = 1'b0;
        #1;
        checks += 2;
        if (tx_line !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_line: got %b, expected 1", tx_line); end
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b, expected 0", tx_busy); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        busAccess(1'b0, A_STATUS, 32'd0, F_WORD, sc, rd);
        checks++;
        if (rd !== STATUS_IDLE) begin errors++; $display("[TB] FAIL status_after_abort: got %h, expected %h", rd, STATUS_IDLE); end
        busAccess(1'b0, A_DIVISOR, 32'd0, F_WORD, sc, rd);
        checks++;
        if (rd !== 32'd104) begin errors++; $display("[TB] FAIL divisor_after_abort: got %0d, expected 104", rd); end
    endtask

    initial begin
        test_reset();
        test_register_read();
        test_tx_frame();
        test_back_to_back();
        test_divisor();
        test_reserved_funct3();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
